vp_sequencer: RTL and testbench

Program sequencer for the vector processor. Software or a test harness pushes a short program of vector operations (load, store, add, multiply) into an internal FIFO. On `start`, the sequencer issues one operation per cycle to the processor through a gated issue interface. Before issuing, it screens load/store addresses against the memory bound, watches the processor's `out_of_bound` flag as a backstop, and stops in a sticky fault state on any violation.

---
 rtl/vp_sequencer_if.sv | 27 ++
 rtl/vp_sequencer.sv | 182 ++++++++++++++++++
 tb/tb_vp_sequencer.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vp_sequencer_if.sv
// Program-load channel into the sequencer and issue channel out to the vector processor.
// master is the harness/processor side, slave is the sequencer side.
interface vp_sequencer_if #(
    parameter int unsigned ADDR_W = 9
);
    logic              prog_valid;
    logic              prog_ready;
    logic [1:0]        prog_instr;
    logic [ADDR_W-1:0] prog_addr;
    logic [1:0]        prog_reg;

    logic              vp_en;
    logic [1:0]        vp_instruction;
    logic [ADDR_W-1:0] vp_mem_addr;
    logic [1:0]        vp_reg_select;
    logic              vp_out_of_bound;

    modport master (
        output prog_valid, prog_instr, prog_addr, prog_reg, vp_out_of_bound,
        input  prog_ready, vp_en, vp_instruction, vp_mem_addr, vp_reg_select
    );

    modport slave (
        input  prog_valid, prog_instr, prog_addr, prog_reg, vp_out_of_bound,
        output prog_ready, vp_en, vp_instruction, vp_mem_addr, vp_reg_select
    );
endinterface

// File: rtl/vp_sequencer.sv
// Vector-processor program sequencer: queues a short program, issues one op per cycle,
// screens load/store bounds and latches a sticky fault on any violation.
module vp_sequencer #(
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned ADDR_W    = 9,
    parameter int unsigned MEM_WORDS = 512,
    parameter int unsigned LANES     = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    vp_sequencer_if.slave     bus,
    input  logic              start,
    input  logic              clear,
    output logic              busy,
    output logic              done,
    output logic              fault,
    output logic [1:0]        fault_code,
    output logic [ADDR_W-1:0] fault_addr,
    output logic [7:0]        issued_count
);
    localparam int unsigned       PTR_W    = $clog2(DEPTH);
    localparam int unsigned       CNT_W    = PTR_W + 1;
    localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(DEPTH);
    localparam logic [ADDR_W-1:0] MAX_BASE = ADDR_W'(MEM_WORDS - LANES);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] FAULT = 2'd2;

    logic [1:0]        instr_mem [DEPTH];
    logic [ADDR_W-1:0] addr_mem  [DEPTH];
    logic [1:0]        reg_mem   [DEPTH];

    logic [1:0]        state_q, state_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              prog_ready_q, prog_ready_d;
    logic              vp_en_q, vp_en_d;
    logic [1:0]        vp_instr_q, vp_instr_d;
    logic [ADDR_W-1:0] vp_addr_q, vp_addr_d;
    logic [1:0]        vp_reg_q, vp_reg_d;
    logic              done_q, done_d;
    logic [1:0]        fault_code_q, fault_code_d;
    logic [ADDR_W-1:0] fault_addr_q, fault_addr_d;
    logic [7:0]        issued_q, issued_d;
    logic              push, pop, flush;

    logic [1:0]        head_instr;
    logic [ADDR_W-1:0] head_addr;
    logic [1:0]        head_reg;

    assign head_instr = instr_mem[rd_ptr_q];
    assign head_addr  = addr_mem[rd_ptr_q];
    assign head_reg   = reg_mem[rd_ptr_q];

    always_comb begin
        state_d      = state_q;
        vp_en_d      = 1'b0;
        vp_instr_d   = vp_instr_q;
        vp_addr_d    = vp_addr_q;
        vp_reg_d     = vp_reg_q;
        done_d       = 1'b0;
        fault_code_d = fault_code_q;
        fault_addr_d = fault_addr_q;
        issued_d     = issued_q;
        pop          = 1'b0;
        flush        = 1'b0;
        push         = bus.prog_valid && prog_ready_q;

        // Processor-reported bound violation outranks everything else on this edge.
        if (vp_en_q && bus.vp_out_of_bound) begin
            state_d      = FAULT;
            fault_code_d = 2'b10;
            fault_addr_d = vp_addr_q;
            flush        = 1'b1;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        issued_d = 8'd0;
                        if (count_q == '0) done_d  = 1'b1;
                        else               state_d = RUN;
                    end
                end
                RUN: begin
                    if (count_q != '0) begin
                        pop = 1'b1;
                        // Loads/stores (opcode bit 1 clear) must fit a full register's span.
                        if (!head_instr[1] && (head_addr > MAX_BASE)) begin
                            state_d      = FAULT;
                            fault_code_d = 2'b01;
                            fault_addr_d = head_addr;
                            flush        = 1'b1;
                        end else begin
                            vp_en_d    = 1'b1;
                            vp_instr_d = head_instr;
                            vp_addr_d  = head_addr;
                            vp_reg_d   = head_reg;
                            issued_d   = issued_q + 8'd1;
                        end
                    end else begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
                FAULT: begin
                    if (clear) begin
                        state_d      = IDLE;
                        fault_code_d = 2'b00;
                        fault_addr_d = '0;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
        prog_ready_d = (state_d != FAULT) && (count_d != FULL_CNT);
    end

    always_ff @(posedge clk) begin
        if (push) begin
            instr_mem[wr_ptr_q] <= bus.prog_instr;
            addr_mem[wr_ptr_q]  <= bus.prog_addr;
            reg_mem[wr_ptr_q]   <= bus.prog_reg;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            prog_ready_q <= 1'b1;
            vp_en_q      <= 1'b0;
            vp_instr_q   <= 2'b00;
            vp_addr_q    <= '0;
            vp_reg_q     <= 2'b00;
            done_q       <= 1'b0;
            fault_code_q <= 2'b00;
            fault_addr_q <= '0;
            issued_q     <= 8'd0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            prog_ready_q <= prog_ready_d;
            vp_en_q      <= vp_en_d;
            vp_instr_q   <= vp_instr_d;
            vp_addr_q    <= vp_addr_d;
            vp_reg_q     <= vp_reg_d;
            done_q       <= done_d;
            fault_code_q <= fault_code_d;
            fault_addr_q <= fault_addr_d;
            issued_q     <= issued_d;
        end
    end

    assign bus.prog_ready     = prog_ready_q;
    assign bus.vp_en          = vp_en_q;
    assign bus.vp_instruction = vp_instr_q;
    assign bus.vp_mem_addr    = vp_addr_q;
    assign bus.vp_reg_select  = vp_reg_q;
    assign busy               = (state_q == RUN);
    assign fault              = (state_q == FAULT);
    assign done               = done_q;
    assign fault_code         = fault_code_q;
    assign fault_addr         = fault_addr_q;
    assign issued_count       = issued_q;
endmodule

// File: tb/tb_vp_sequencer.sv
// Scoreboard bench for vp_sequencer: a list-level program model predicts the issued ops and
// the end state; a negedge monitor checks every issue strobe against the expected queue.
module tb_vp_sequencer;
    localparam int unsigned ADDR_W   = 9;
    localparam int          MAX_BASE = 512 - 16;

    typedef struct packed {
        logic [1:0]        instr;
        logic [ADDR_W-1:0] addr;
        logic [1:0]        rsel;
    } op_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic clear = 1'b0;
    logic busy, done, fault;
    logic [1:0]        fault_code;
    logic [ADDR_W-1:0] fault_addr;
    logic [7:0]        issued_count;

    vp_sequencer_if #(.ADDR_W(ADDR_W)) bus ();

    vp_sequencer #(
        .DEPTH(8), .ADDR_W(ADDR_W), .MEM_WORDS(512), .LANES(16)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .start(start), .clear(clear),
        .busy(busy), .done(done), .fault(fault), .fault_code(fault_code),
        .fault_addr(fault_addr), .issued_count(issued_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    op_t prog[$];
    op_t exp_q[$];
    int oob_at = 0;
    int issue_cnt = 0;
    int first_cyc = -1;
    int last_cyc = -1;
    int cyc = 0;
    logic [1:0]        exp_code;
    logic [ADDR_W-1:0] exp_faddr;
    int exp_issued;

    always @(posedge clk) cyc = cyc + 1;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    function automatic op_t mk(int instr, int addr, int rsel);
        op_t o;
        o.instr = 2'(instr);
        o.addr  = ADDR_W'(addr);
        o.rsel  = 2'(rsel);
        return o;
    endfunction

    function automatic op_t rand_op();
        op_t o;
        o.instr = 2'($urandom_range(0, 3));
        o.rsel  = 2'($urandom_range(0, 3));
        if ($urandom_range(0, 4) == 0) o.addr = ADDR_W'($urandom_range(490, 511));
        else                           o.addr = ADDR_W'($urandom_range(0, MAX_BASE));
        return o;
    endfunction

    // Program-level model: ops issue in order until a bad load/store or the injected flag.
    function automatic void plan();
        exp_code   = 2'b00;
        exp_faddr  = '0;
        exp_issued = 0;
        exp_q.delete();
        foreach (prog[i]) begin
            if (prog[i].instr < 2 && int'(prog[i].addr) > MAX_BASE) begin
                exp_code  = 2'b01;
                exp_faddr = prog[i].addr;
                break;
            end
            exp_q.push_back(prog[i]);
            exp_issued++;
            if (exp_issued == oob_at) begin
                exp_code  = 2'b10;
                exp_faddr = prog[i].addr;
                break;
            end
        end
    endfunction

    // Monitor and processor stand-in: compares each issue, raises the bound flag on request.
    always @(negedge clk) begin
        op_t got;
        if (!rst_n || !bus.vp_en) begin
            bus.vp_out_of_bound = 1'b0;
        end else begin
            got.instr = bus.vp_instruction;
            got.addr  = bus.vp_mem_addr;
            got.rsel  = bus.vp_reg_select;
            issue_cnt++;
            if (first_cyc < 0) first_cyc = cyc;
            last_cyc = cyc;
            chk("issue_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) chk("issue_op", 32'(got), 32'(exp_q.pop_front()));
            bus.vp_out_of_bound = (issue_cnt == oob_at);
        end
    end

    task automatic push(op_t op);
        bit acc = 1'b0;
        @(negedge clk);
        bus.prog_valid = 1'b1;
        bus.prog_instr = op.instr;
        bus.prog_addr  = op.addr;
        bus.prog_reg   = op.rsel;
        for (int w = 0; w < 100 && !acc; w++) begin
            acc = bus.prog_ready;
            @(posedge clk);
            if (!acc) @(negedge clk);
        end
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL push_accept: got no ready expected ready within 100 cycles");
        end
    endtask

    task automatic idle_inputs();
        @(negedge clk);
        bus.prog_valid = 1'b0;
    endtask

    task automatic issue_start();
        issue_cnt = 0;
        first_cyc = -1;
        last_cyc  = -1;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic finish_check(string name);
        bit seen = 1'b0;
        for (int c = 0; c < 300 && !seen; c++) begin
            @(negedge clk);
            #1;
            if (done || fault) seen = 1'b1;
        end
        chk({name, "_ended"}, 32'(seen), 32'd1);
        chk({name, "_fault"}, 32'(fault), 32'(exp_code != 2'b00));
        chk({name, "_done"}, 32'(done), 32'(exp_code == 2'b00));
        chk({name, "_code"}, 32'(fault_code), 32'(exp_code));
        chk({name, "_faddr"}, 32'(fault_addr), 32'(exp_faddr));
        chk({name, "_issued_count"}, 32'(issued_count), 32'(exp_issued));
        chk({name, "_issue_strobes"}, 32'(issue_cnt), 32'(exp_issued));
        chk({name, "_leftover"}, 32'(exp_q.size()), 32'd0);
        chk({name, "_ready"}, 32'(bus.prog_ready), 32'(exp_code == 2'b00));
        chk({name, "_busy"}, 32'(busy), 32'd0);
        if (issue_cnt > 0) chk({name, "_no_gaps"}, 32'(last_cyc - first_cyc + 1), 32'(issue_cnt));
        if (exp_code == 2'b00) begin
            @(negedge clk);
            #1 chk({name, "_done_one_cycle"}, 32'(done), 32'd0);
        end else begin
            @(negedge clk);
            clear = 1'b1;
            @(posedge clk);
            #1 clear = 1'b0;
            chk({name, "_clr_fault"}, 32'(fault), 32'd0);
            chk({name, "_clr_code"}, 32'(fault_code), 32'd0);
            chk({name, "_clr_faddr"}, 32'(fault_addr), 32'd0);
            chk({name, "_clr_ready"}, 32'(bus.prog_ready), 32'd1);
        end
    endtask

    task automatic run_prog(string name);
        plan();
        foreach (prog[i]) push(prog[i]);
        idle_inputs();
        issue_start();
        finish_check(name);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int len;
        bus.prog_valid = 1'b0;
        bus.prog_instr = 2'b00;
        bus.prog_addr  = '0;
        bus.prog_reg   = 2'b00;
        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(bus.prog_ready), 32'd1);
        chk("rst_vp_en", 32'(bus.vp_en), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_fault", 32'(fault), 32'd0);
        chk("rst_issued", 32'(issued_count), 32'd0);
        chk("rst_vp_addr", 32'(bus.vp_mem_addr), 32'd0);
        rst_n = 1'b1;

        oob_at = 0;
        prog.delete();
        prog.push_back(mk(0, 0, 0));
        prog.push_back(mk(0, 16, 1));
        prog.push_back(mk(2, 5, 2));
        prog.push_back(mk(3, 9, 3));
        run_prog("basic");

        prog.delete();
        prog.push_back(mk(0, 500, 0));
        run_prog("load500");

        prog.delete();
        prog.push_back(mk(0, 496, 1));
        prog.push_back(mk(2, 511, 2));
        run_prog("bound_ok");

        prog.delete();
        prog.push_back(mk(0, 497, 0));
        run_prog("bound_497");

        // Fill to capacity, offer a refused ninth entry, then stream more in during RUN.
        prog.delete();
        for (int i = 0; i < 14; i++) prog.push_back(mk(i % 4, i * 8, i % 4));
        plan();
        for (int i = 0; i < 8; i++) push(prog[i]);
        idle_inputs();
        #1 chk("full_ready_low", 32'(bus.prog_ready), 32'd0);
        bus.prog_valid = 1'b1;
        bus.prog_instr = 2'b11;
        bus.prog_addr  = ADDR_W'(300);
        bus.prog_reg   = 2'b01;
        repeat (2) @(posedge clk);
        #1 chk("ninth_refused", 32'(bus.prog_ready), 32'd0);
        bus.prog_valid = 1'b0;
        issue_start();
        for (int i = 8; i < 14; i++) push(prog[i]);
        idle_inputs();
        finish_check("stream");

        oob_at = 2;
        prog.delete();
        prog.push_back(mk(0, 8, 0));
        prog.push_back(mk(1, 40, 1));
        prog.push_back(mk(2, 0, 2));
        prog.push_back(mk(0, 32, 3));
        run_prog("oob");
        oob_at = 0;

        // Reset during the second issued op.
        prog.delete();
        for (int i = 0; i < 4; i++) prog.push_back(mk(i % 2, 64 + i * 16, i));
        plan();
        foreach (prog[i]) push(prog[i]);
        idle_inputs();
        issue_start();
        begin
            bit hit = 1'b0;
            for (int c = 0; c < 50 && !hit; c++) begin
                @(negedge clk);
                #1;
                if (issue_cnt >= 2) hit = 1'b1;
            end
            chk("rst_mid_reached", 32'(hit), 32'd1);
        end
        rst_n = 1'b0;
        #1;
        chk("rst_mid_vp_en", 32'(bus.vp_en), 32'd0);
        chk("rst_mid_busy", 32'(busy), 32'd0);
        chk("rst_mid_issued", 32'(issued_count), 32'd0);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        prog.delete();
        run_prog("rst_empty");

        for (int r = 0; r < 25; r++) begin
            len = $urandom_range(1, 8);
            prog.delete();
            for (int i = 0; i < len; i++) prog.push_back(rand_op());
            oob_at = ($urandom_range(0, 3) == 0) ? $urandom_range(1, len) : 0;
            run_prog($sformatf("rand%0d", r));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
